msg_encoder_tx: RTL and testbench



---
 rtl/msg_encoder_tx_if.sv | 25 ++
 rtl/msg_encoder_tx.sv | 140 ++++++++++++++
 tb/tb_msg_encoder_tx.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/msg_encoder_tx_if.sv
// Host/transmitter signal bundle for msg_encoder_tx: frame request inputs,
// the byte-serial valid/ready channel and the frame status pulses.
interface msg_encoder_tx_if #(
  parameter int NBYTES = 8
);
  logic                  start;
  logic [7:0]            key;
  logic [8*NBYTES-1:0]   msg;
  logic                  tx_ready;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    input  start, key, msg, tx_ready,
    output tx_data, tx_valid, busy, done, err
  );

  modport slave (
    output start, key, msg, tx_ready,
    input  tx_data, tx_valid, busy, done, err
  );
endinterface

// File: rtl/msg_encoder_tx.sv
// Keyed frame encoder: key byte, NBYTES key-bit-masked message bytes and,
// when MSG_ENCODER_CHECKSUM_EN is defined, a trailing XOR checksum byte.
module msg_encoder_tx #(
  parameter int NBYTES = 8
) (
  input  logic             clk,
  input  logic             rst,
  msg_encoder_tx_if.master bus
);

  localparam int             CW   = $clog2(NBYTES + 1);
  localparam int             IW   = $clog2(NBYTES);
  localparam logic [CW-1:0]  LAST = CW'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY,
    S_DATA,
`ifdef MSG_ENCODER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE
  } state_t;

  state_t                  state, state_n;
  logic [CW-1:0]           cnt;
  logic [7:0]              key_r;
  logic [NBYTES-1:0][7:0]  msg_r;
  logic                    err_r;
`ifdef MSG_ENCODER_CHECKSUM_EN
  logic [7:0]              csum_r;
`endif

  logic                    load, reject, hs;
  logic [7:0]              enc_byte;
  logic [7:0]              tx_data_c;
  logic                    tx_valid_c, busy_c, done_c;

  // A key bit of 1 inverts the whole byte at that position.
  assign enc_byte = msg_r[cnt[IW-1:0]] ^ {8{key_r[cnt[IW-1:0]]}};
  assign hs       = tx_valid_c & bus.tx_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    state_n    = state;
    load       = 1'b0;
    reject     = 1'b0;
    tx_data_c  = '0;
    tx_valid_c = 1'b0;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.key < 8'd5) begin
            load    = 1'b1;
            state_n = S_KEY;
          end else begin
            reject  = 1'b1;
          end
        end
      end
      S_KEY: begin
        tx_data_c  = key_r;
        tx_valid_c = 1'b1;
        busy_c     = 1'b1;
        if (bus.tx_ready) state_n = S_DATA;
      end
      S_DATA: begin
        tx_data_c  = enc_byte;
        tx_valid_c = 1'b1;
        busy_c     = 1'b1;
        if (bus.tx_ready && cnt == LAST) begin
`ifdef MSG_ENCODER_CHECKSUM_EN
          state_n = S_CSUM;
`else
          state_n = S_DONE;
`endif
        end
      end
`ifdef MSG_ENCODER_CHECKSUM_EN
      S_CSUM: begin
        tx_data_c  = csum_r;
        tx_valid_c = 1'b1;
        busy_c     = 1'b1;
        if (bus.tx_ready) state_n = S_DONE;
      end
`endif
      S_DONE: begin
        done_c  = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // NOTE: msg_r is a plain register bank rather than a RAM, so it is reset
  // along with the rest of the datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      key_r  <= '0;
      msg_r  <= '0;
      err_r  <= 1'b0;
`ifdef MSG_ENCODER_CHECKSUM_EN
      csum_r <= '0;
`endif
    end else begin
      err_r <= reject;
      if (load) begin
        key_r  <= bus.key;
        msg_r  <= bus.msg;
        cnt    <= '0;
`ifdef MSG_ENCODER_CHECKSUM_EN
        csum_r <= '0;
`endif
      end else if (hs) begin
        if (state == S_DATA && cnt != LAST) cnt <= cnt + 1'b1;
`ifdef MSG_ENCODER_CHECKSUM_EN
        if (state == S_KEY || state == S_DATA) csum_r <= csum_r ^ tx_data_c;
`endif
      end
    end
  end

  assign bus.tx_data  = tx_data_c;
  assign bus.tx_valid = tx_valid_c;
  assign bus.busy     = busy_c;
  assign bus.done     = done_c;
  assign bus.err      = err_r;

endmodule

// File: tb/tb_msg_encoder_tx.sv
// Bench for msg_encoder_tx: a byte-queue reference model checked every cycle,
// directed frames with literal expectations, then randomized traffic.
module tb_msg_encoder_tx;

`ifdef MSG_ENCODER_CHECKSUM_EN
  localparam int FRAME_LEN = 10;
`else
  localparam int FRAME_LEN = 9;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  msg_encoder_tx_if #(.NBYTES(8)) bus ();

  msg_encoder_tx #(.NBYTES(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte idx of the frame for key k / message m, straight from the framing rules.
  function automatic logic [7:0] frame_byte(input logic [7:0] k, input logic [63:0] m, input int idx);
    logic [7:0] acc;
    if (idx == 0) return k;
    if (idx <= 8) return m[8*(idx-1) +: 8] ^ {8{k[idx-1]}};
    acc = 8'h00;
    for (int j = 0; j <= 8; j++) acc = acc ^ frame_byte(k, m, j);
    return acc;
  endfunction

  // Reference model: bytes still owed to the transmitter, plus pending pulses.
  logic [7:0] mq[$];
  bit         m_done = 1'b0;
  bit         m_err  = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_done = 1'b0;
      m_err  = 1'b0;
    end else begin
      bit err_n;
      err_n = 1'b0;
      if (m_done) begin
        m_done = 1'b0;
      end else if (mq.size() > 0) begin
        if (bus.tx_ready) begin
          void'(mq.pop_front());
          if (mq.size() == 0) m_done = 1'b1;
        end
      end else if (bus.start) begin
        if (bus.key < 8'd5) begin
          for (int i = 0; i < FRAME_LEN; i++) mq.push_back(frame_byte(bus.key, bus.msg, i));
        end else begin
          err_n = 1'b1;
        end
      end
      m_err = err_n;
    end
  end

  always @(negedge clk) begin
    logic [7:0] exp_data;
    exp_data = (mq.size() > 0) ? mq[0] : 8'h00;
    check("model_tx_valid", bus.tx_valid, mq.size() > 0);
    check("model_tx_data",  bus.tx_data,  exp_data);
    check("model_busy",     bus.busy,     mq.size() > 0);
    check("model_done",     bus.done,     m_done);
    check("model_err",      bus.err,      m_err);
  end

  // Records every byte actually handed over while enabled.
  bit         mon_en = 1'b0;
  logic [7:0] xfer_q[$];
  always @(negedge clk) begin
    if (mon_en && !rst && bus.tx_valid && bus.tx_ready) xfer_q.push_back(bus.tx_data);
  end

  task automatic wait_done(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, seen, 1'b1);
  endtask

  initial begin
    logic [7:0] lit1 [10];
    logic [7:0] tog_lit [10];
    logic [63:0] m_rst;

    lit1    = '{8'h03, 8'hFF, 8'hFE, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h03};
    tog_lit = '{8'h00, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h00};

    bus.start    = 1'b0;
    bus.key      = 8'h00;
    bus.msg      = 64'h0;
    bus.tx_ready = 1'b0;

    // Pin the model against hand-computed frame bytes.
    check("pin_key",  frame_byte(8'h03, 64'h0706050403020100, 0), 8'h03);
    check("pin_b0",   frame_byte(8'h03, 64'h0706050403020100, 1), 8'hFF);
    check("pin_b1",   frame_byte(8'h03, 64'h0706050403020100, 2), 8'hFE);
    check("pin_b7",   frame_byte(8'h03, 64'h0706050403020100, 8), 8'h07);
    check("pin_csum", frame_byte(8'h03, 64'h0706050403020100, 9), 8'h03);

    // Reset state.
    @(negedge clk);
    check("rst_tx_valid", bus.tx_valid, 1'b0);
    check("rst_tx_data",  bus.tx_data,  8'h00);
    check("rst_busy",     bus.busy,     1'b0);
    check("rst_done",     bus.done,     1'b0);
    check("rst_err",      bus.err,      1'b0);
    @(posedge clk); #1 rst = 1'b0;

    // Reference frame with tx_ready held high.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.key = 8'h03; bus.msg = 64'h0706050403020100; bus.tx_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.key = 8'($urandom); bus.msg = {$urandom, $urandom};
    for (int k = 0; k < FRAME_LEN; k++) begin
      @(negedge clk);
      check("seq_valid", bus.tx_valid, 1'b1);
      check($sformatf("seq_byte%0d", k), bus.tx_data, lit1[k]);
    end
    @(negedge clk);
    check("seq_done", bus.done, 1'b1);
    check("seq_busy_at_done", bus.busy, 1'b0);
    @(negedge clk);
    check("seq_done_one_cycle", bus.done, 1'b0);

    // Illegal key is rejected with a single err pulse.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.key = 8'h05;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("err_pulse", bus.err, 1'b1);
    check("err_no_valid", bus.tx_valid, 1'b0);
    check("err_no_busy", bus.busy, 1'b0);
    @(negedge clk);
    check("err_one_cycle", bus.err, 1'b0);
    check("err_still_idle", bus.busy, 1'b0);

    // tx_ready toggling: nothing lost or duplicated.
    xfer_q.delete();
    mon_en = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.key = 8'h00; bus.msg = 64'hAA55AA55AA55AA55; bus.tx_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.tx_ready = ~bus.tx_ready;
    end
    mon_en = 1'b0;
    bus.tx_ready = 1'b1;
    check("tog_count", xfer_q.size(), FRAME_LEN);
    for (int k = 0; k < FRAME_LEN; k++) begin
      logic [7:0] got;
      got = (k < xfer_q.size()) ? xfer_q[k] : 8'hXX;
      check($sformatf("tog_byte%0d", k), got, tog_lit[k]);
    end
    repeat (3) @(negedge clk);

    // start held high: one frame, next key byte once start is resampled in IDLE.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.key = 8'h01; bus.msg = {$urandom, $urandom};
    wait_done("hold_done_timeout", 40);
    @(negedge clk);
    check("hold_idle_after_done", bus.tx_valid, 1'b0);
    @(negedge clk);
    check("hold_second_valid", bus.tx_valid, 1'b1);
    check("hold_second_key", bus.tx_data, 8'h01);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done("hold_second_done_timeout", 40);
    repeat (2) @(negedge clk);

    // Asynchronous reset in DATA at cnt=4, then a clean frame.
    m_rst = {$urandom, $urandom};
    @(posedge clk); #1;
    bus.start = 1'b1; bus.key = 8'h02; bus.msg = m_rst;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_mid_byte4", bus.tx_data, frame_byte(8'h02, m_rst, 5));
    #2 rst = 1'b1;
    #1;
    check("rst_mid_valid", bus.tx_valid, 1'b0);
    check("rst_mid_busy", bus.busy, 1'b0);
    check("rst_mid_data", bus.tx_data, 8'h00);
    @(negedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.key = 8'h04; bus.msg = m_rst;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("post_rst_key", bus.tx_data, 8'h04);
    @(negedge clk);
    check("post_rst_b0", bus.tx_data, frame_byte(8'h04, m_rst, 1));
    wait_done("post_rst_done_timeout", 40);

    // Randomized traffic, including illegal keys and stray async resets.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      bus.start    = ($urandom_range(0, 3) == 0);
      bus.key      = 8'($urandom_range(0, 6));
      bus.msg      = {$urandom, $urandom};
      bus.tx_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        #2 rst = 1'b0;
      end
    end

    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
